// File: rtl/sm_debug_ctrl_pkg.sv
// Shared definitions for the CPU debug controller: host op codes,
// FSM state encodings and a helper that builds the status word.
package sm_debug_ctrl_pkg;

  // Host command op codes carried on cmdOp
  typedef enum logic [1:0] {
    DBG_OP_READ   = 2'd0,
    DBG_OP_WRITE  = 2'd1,
    DBG_OP_RUNCTL = 2'd2,
    DBG_OP_STEP   = 2'd3
  } dbg_op_e;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR      = 3'd2,
    ST_STEP    = 3'd3,
    ST_RESP    = 3'd4
  } dbg_state_e;

  // Response word for non-READ commands: halted flag in bit 0
  function automatic logic [31:0] status_word(input logic halted);
    return {31'd0, halted};
  endfunction

endpackage

// File: rtl/sm_debug_ctrl_stepper.sv
// Loadable step down-counter for single-step / N-step runs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       load i_load_val into the counter
//   i_load_val   step count N
//   i_dec        decrement request (ignored once the count is zero)
//   o_last       count == 1: this is the final enabled CPU cycle
module sm_debug_ctrl_stepper #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [STEP_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_last
);

  logic [STEP_W-1:0] r_count;
  logic              w_zero;

  assign w_zero = (r_count == {STEP_W{1'b0}});
  assign o_last = (r_count == {{(STEP_W-1){1'b0}}, 1'b1});

  // Step counter: load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {STEP_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_count <= r_count - {{(STEP_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sm_debug_ctrl.sv
// CPU debug port responder: halts/runs/steps the CPU and reads/writes
// the register file under host command. One command outstanding.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmdValid/cmdReady          command handshake; cmdOp/cmdAddr/cmdData payload
//   rspValid/rspReady          response handshake; rspData/rspErr payload
//   extRegAddr -> regAddr      board register select, overridden during READ
//   regData                    register file read data
//   dbgWe/dbgWaddr/dbgWdata    register file debug write port
//   cpuClkEn, halted           CPU clock enable and debugger-halt status
module sm_debug_ctrl
  import sm_debug_ctrl_pkg::*;
#(
  parameter int STEP_W     = 16,
  parameter int RD_LAT     = 1,
  parameter bit RESET_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [1:0]  cmdOp,
  input  logic [4:0]  cmdAddr,
  input  logic [31:0] cmdData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspErr,
  input  logic [4:0]  extRegAddr,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        dbgWe,
  output logic [4:0]  dbgWaddr,
  output logic [31:0] dbgWdata,
  output logic        cpuClkEn,
  output logic        halted
);

  dbg_state_e        r_state;
  dbg_state_e        w_state_nxt;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;
  logic              r_dbg_we;
  logic [4:0]        r_dbg_waddr;
  logic [31:0]       r_dbg_wdata;
  logic              r_clk_en;
  logic              r_halted;
  logic              r_addr_sel;
  logic [4:0]        r_rd_addr;
  logic [1:0]        r_rd_cnt;
  logic              w_accept;
  logic              w_write_ok;
  logic [STEP_W-1:0] w_step_n;
  logic              w_step_nz;
  logic              w_step_load;
  logic              w_step_last;

  assign w_accept    = cmdValid && r_cmd_ready;
  assign w_write_ok  = r_halted && (cmdAddr != 5'd0);
  assign w_step_n    = cmdData[STEP_W-1:0];
  assign w_step_nz   = (w_step_n != {STEP_W{1'b0}});
  assign w_step_load = w_accept && (dbg_op_e'(cmdOp) == DBG_OP_STEP) && w_step_nz;

  assign cmdReady = r_cmd_ready;
  assign rspValid = r_rsp_valid;
  assign rspData  = r_rsp_data;
  assign rspErr   = r_rsp_err;
  assign dbgWe    = r_dbg_we;
  assign dbgWaddr = r_dbg_waddr;
  assign dbgWdata = r_dbg_wdata;
  assign cpuClkEn = r_clk_en;
  assign halted   = r_halted;
  // Mux select is registered; the board address passes straight through otherwise
  assign regAddr  = r_addr_sel ? r_rd_addr : extRegAddr;

  sm_debug_ctrl_stepper #(.STEP_W(STEP_W)) u_stepper (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_step_load),
    .i_load_val (w_step_n),
    .i_dec      (r_state == ST_STEP),
    .o_last     (w_step_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (dbg_op_e'(cmdOp))
            DBG_OP_READ:   w_state_nxt = ST_RD_WAIT;
            DBG_OP_WRITE:  w_state_nxt = w_write_ok ? ST_WR : ST_RESP;
            DBG_OP_RUNCTL: w_state_nxt = ST_RESP;
            DBG_OP_STEP:   w_state_nxt = w_step_nz ? ST_STEP : ST_RESP;
            default:       w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_rd_cnt == 2'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR:   w_state_nxt = ST_RESP;
      ST_STEP: begin
        if (w_step_last) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_RESP: begin
        if (rspReady) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: handshake flags, CPU run control, write port and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_dbg_we    <= 1'b0;
      r_dbg_waddr <= 5'd0;
      r_dbg_wdata <= 32'd0;
      r_clk_en    <= !RESET_HALT;
      r_halted    <= RESET_HALT;
      r_addr_sel  <= 1'b0;
      r_rd_addr   <= 5'd0;
      r_rd_cnt    <= 2'd0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rsp_err <= 1'b0;
            case (dbg_op_e'(cmdOp))
              DBG_OP_READ: begin
                r_addr_sel <= 1'b1;
                r_rd_addr  <= cmdAddr;
                r_rd_cnt   <= 2'(RD_LAT - 1);
              end
              DBG_OP_WRITE: begin
                if (w_write_ok) begin
                  r_dbg_we    <= 1'b1;
                  r_dbg_waddr <= cmdAddr;
                  r_dbg_wdata <= cmdData;
                end else begin
                  r_rsp_err  <= 1'b1;
                  r_rsp_data <= status_word(r_halted);
                end
              end
              DBG_OP_RUNCTL: begin
                r_halted   <= cmdData[0];
                r_clk_en   <= !cmdData[0];
                r_rsp_data <= status_word(cmdData[0]);
              end
              DBG_OP_STEP: begin
                if (w_step_nz) begin
                  // CPU runs during the step window, then refreezes
                  r_clk_en <= 1'b1;
                  r_halted <= 1'b0;
                end else begin
                  r_rsp_data <= status_word(r_halted);
                end
              end
              default: r_rsp_err <= 1'b0;
            endcase
          end
        end
        ST_RD_WAIT: begin
          if (r_rd_cnt == 2'd0) begin
            r_rsp_data <= regData;
          end else begin
            r_rd_cnt <= r_rd_cnt - 2'd1;
          end
        end
        ST_WR: begin
          r_dbg_we   <= 1'b0;
          r_rsp_data <= status_word(r_halted);
        end
        ST_STEP: begin
          if (w_step_last) begin
            r_clk_en   <= 1'b0;
            r_halted   <= 1'b1;
            r_rsp_data <= status_word(1'b1);
          end
        end
        ST_RESP: begin
          // READ keeps regAddr on the read index until the response is taken
          if (rspReady) begin
            r_addr_sel <= 1'b0;
          end
        end
        default: r_addr_sel <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_debug_ctrl.sv
module tb_sm_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmdOp = 2'd0;
  logic [4:0]  cmdAddr = 5'd0;
  logic [31:0] cmdData = 32'd0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspData;
  logic        rspErr;
  logic [4:0]  extRegAddr = 5'd7;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        dbgWe;
  logic [4:0]  dbgWaddr;
  logic [31:0] dbgWdata;
  logic        cpuClkEn;
  logic        halted;

  // Environment: CPU PC counter and register file fed by the debug write port
  logic [31:0] pc;
  logic [31:0] rf [32];
  int          en_cnt;
  int          we_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  sm_debug_ctrl #(.STEP_W(16), .RD_LAT(1), .RESET_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdAddr(cmdAddr), .cmdData(cmdData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
    .extRegAddr(extRegAddr), .regAddr(regAddr), .regData(regData),
    .dbgWe(dbgWe), .dbgWaddr(dbgWaddr), .dbgWdata(dbgWdata),
    .cpuClkEn(cpuClkEn), .halted(halted)
  );

  assign regData = (regAddr == 5'd0) ? pc : rf[regAddr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (cpuClkEn) begin
        pc     <= pc + 32'd1;
        en_cnt <= en_cnt + 1;
      end
      if (dbgWe) begin
        rf[dbgWaddr] <= dbgWdata;
        we_cnt       <= we_cnt + 1;
      end
    end
  end

  initial begin
    en_cnt = 0;
    we_cnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and wait until the response is valid.
  task automatic issue(input logic [1:0] op, input logic [4:0] addr,
                       input logic [31:0] data, output int lat);
    chk("cmd_ready", {31'd0, cmdReady}, 32'd1);
    cmdValid = 1'b1; cmdOp = op; cmdAddr = addr; cmdData = data;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rspValid && lat < 400);
    if (!rspValid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  // Take the pending response and return to a negedge with the FSM idle.
  task automatic take_rsp();
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata,
                        output logic err, output int lat);
    issue(op, addr, data, lat);
    rdata = rspData;
    err   = rspErr;
    take_rsp();
  endtask

  logic [31:0] rd, pc_a, pc_b;
  logic        er;
  int          lat, en0, we0;

  initial begin
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_cmdReady", {31'd0, cmdReady}, 32'd1);
    chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
    chk("rst_rspData",  rspData, 32'd0);
    chk("rst_rspErr",   {31'd0, rspErr}, 32'd0);
    chk("rst_dbgWe",    {31'd0, dbgWe}, 32'd0);
    chk("rst_dbgWaddr", {27'd0, dbgWaddr}, 32'd0);
    chk("rst_dbgWdata", dbgWdata, 32'd0);
    chk("rst_cpuClkEn", {31'd0, cpuClkEn}, 32'd1);
    chk("rst_halted",   {31'd0, halted}, 32'd0);
    chk("rst_regAddr",  {27'd0, regAddr}, 32'd7);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Halt: clock enable drops on the accept edge
    do_cmd(2'd2, 5'd0, 32'd1, rd, er, lat);
    chk("halt_rsp", rd, 32'd1);
    chk("halt_err", {31'd0, er}, 32'd0);
    chk("halt_clken", {31'd0, cpuClkEn}, 32'd0);
    chk("halt_halted", {31'd0, halted}, 32'd1);

    // PC frozen across 10 idle cycles
    do_cmd(2'd0, 5'd0, 32'd0, pc_a, er, lat);
    chk("pc_read_model", pc_a, pc);
    repeat (10) @(negedge clk);
    do_cmd(2'd0, 5'd0, 32'd0, pc_b, er, lat);
    chk("pc_frozen", pc_b, pc_a);

    // Write while halted
    we0 = we_cnt;
    do_cmd(2'd1, 5'd2, 32'h1234, rd, er, lat);
    chk("wr_err", {31'd0, er}, 32'd0);
    chk("wr_we_pulses", we_cnt - we0, 32'd1);
    chk("wr_waddr", {27'd0, dbgWaddr}, 32'd2);
    chk("wr_we_low", {31'd0, dbgWe}, 32'd0);
    do_cmd(2'd0, 5'd2, 32'd0, rd, er, lat);
    chk("rd_back", rd, 32'h1234);

    // STEP 3
    en0 = en_cnt;
    do_cmd(2'd3, 5'd0, 32'd3, rd, er, lat);
    chk("step3_cycles", en_cnt - en0, 32'd3);
    chk("step3_rsp", rd, 32'd1);
    chk("step3_halted", {31'd0, halted}, 32'd1);
    do_cmd(2'd0, 5'd0, 32'd0, rd, er, lat);
    chk("step3_pc", rd, pc_a + 32'd3);

    // STEP 0
    en0 = en_cnt;
    do_cmd(2'd3, 5'd0, 32'd0, rd, er, lat);
    chk("step0_cycles", en_cnt - en0, 32'd0);
    chk("step0_lat_ok", {31'd0, (lat <= 2)}, 32'd1);
    chk("step0_rsp", rd, 32'd1);

    // WRITE to address 0 while halted
    we0 = we_cnt;
    do_cmd(2'd1, 5'd0, 32'hdead, rd, er, lat);
    chk("wr0_err", {31'd0, er}, 32'd1);
    chk("wr0_we", we_cnt - we0, 32'd0);

    // Run, then WRITE while running
    do_cmd(2'd2, 5'd0, 32'd0, rd, er, lat);
    chk("run_rsp", rd, 32'd0);
    chk("run_clken", {31'd0, cpuClkEn}, 32'd1);
    we0 = we_cnt;
    do_cmd(2'd1, 5'd3, 32'h5555, rd, er, lat);
    chk("wrrun_err", {31'd0, er}, 32'd1);
    chk("wrrun_we", we_cnt - we0, 32'd0);
    do_cmd(2'd0, 5'd3, 32'd0, rd, er, lat);
    chk("wrrun_rf", rd, 32'd0);

    // Response held: rspReady low 5 cycles
    issue(2'd0, 5'd2, 32'd0, lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, rspValid}, 32'd1);
      chk("hold_data", rspData, 32'h1234);
      chk("hold_ready", {31'd0, cmdReady}, 32'd0);
      chk("hold_regaddr", {27'd0, regAddr}, 32'd2);
      @(negedge clk);
    end
    take_rsp();
    chk("post_regaddr", {27'd0, regAddr}, 32'd7);
    chk("post_ready", {31'd0, cmdReady}, 32'd1);

    // Reset mid-STEP 100
    do_cmd(2'd2, 5'd0, 32'd1, rd, er, lat);
    cmdValid = 1'b1; cmdOp = 2'd3; cmdAddr = 5'd0; cmdData = 32'd100;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midstep_clken", {31'd0, cpuClkEn}, 32'd1);
    chk("midstep_norsp", {31'd0, rspValid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rspValid", {31'd0, rspValid}, 32'd0);
    chk("abort_clken", {31'd0, cpuClkEn}, 32'd1);
    chk("abort_halted", {31'd0, halted}, 32'd0);
    chk("abort_ready", {31'd0, cmdReady}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_rst_valid", {31'd0, rspValid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
